// File: rtl/enokida_cache_pkg.sv
// Shared types and geometry helpers for the enokida direct-mapped cache.
package enokida_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_REQ  = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_RESP     = 3'd3,
    ST_PF_REQ   = 3'd4,
    ST_PF_WAIT  = 3'd5
  } cache_state_e;

  function automatic int idx_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_width(input int addr_width, input int num_lines);
    return addr_width - $clog2(num_lines) - 2;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/enokida_hint_fifo.sv
// Show-ahead FIFO of prefetch hint addresses; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module enokida_hint_fifo #(
  parameter int ADDR_WIDTH = 16,
  parameter int HINT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] pop_addr,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(HINT_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] mem_r [HINT_DEPTH];
  logic [PW:0]           wr_ptr_r;
  logic [PW:0]           rd_ptr_r;
  logic                  do_pop_s;
  logic                  do_push_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign pop_addr  = mem_r[rd_ptr_r[PW-1:0]];

  // read/write pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // hint storage
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[PW-1:0]] <= push_addr;
  end

endmodule

// File: rtl/enokida_dm_cache.sv
// Direct-mapped write-through data cache with trace-driven prefetch.
// Optional statistics counters are built when ENOKIDA_CACHE_STATS_EN is defined.
module enokida_dm_cache
  import enokida_cache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_LINES       = 64,
  parameter int HINT_DEPTH      = 4,
  parameter int TRACE_ADDR_LSB  = 32,
  parameter int TRACE_VALID_BIT = 127
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    proc_cache_data_req_i,
  input  logic [ADDR_WIDTH-1:0]   proc_cache_data_addr_i,
  input  logic                    proc_cache_data_we_i,
  input  logic [DATA_WIDTH/8-1:0] proc_cache_data_be_i,
  input  logic [DATA_WIDTH-1:0]   proc_cache_data_wdata_i,
  output logic                    proc_cache_data_gnt_o,
  output logic                    proc_cache_data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   proc_cache_data_rdata_o,
  input  logic                    cache_mem_data_gnt_i,
  input  logic                    cache_mem_data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   cache_mem_data_rdata_i,
  output logic                    cache_mem_data_req_o,
  output logic [ADDR_WIDTH-1:0]   cache_mem_data_addr_o,
  output logic                    cache_mem_data_we_o,
  output logic [DATA_WIDTH/8-1:0] cache_mem_data_be_o,
  output logic [DATA_WIDTH-1:0]   cache_mem_data_wdata_o,
  input  logic [127:0]            trace_in,
  input  logic                    trace_capture_enable,
  input  logic                    lock
`ifdef ENOKIDA_CACHE_STATS_EN
  ,
  output logic [31:0]             stat_hits_o,
  output logic [31:0]             stat_misses_o,
  output logic [31:0]             stat_pf_fills_o,
  output logic [31:0]             stat_hint_drops_o
`endif
);

  localparam int IDX   = idx_width(NUM_LINES);
  localparam int TAG_W = tag_width(ADDR_WIDTH, NUM_LINES);
  localparam int BE_W  = DATA_WIDTH / 8;

  cache_state_e            state_r;
  logic [NUM_LINES-1:0]    valid_r;
  logic [TAG_W-1:0]        tag_r  [NUM_LINES];
  logic [DATA_WIDTH-1:0]   data_r [NUM_LINES];

  logic                    mem_req_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic                    mem_we_r;
  logic [BE_W-1:0]         mem_be_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic                    rvalid_r;
  logic [DATA_WIDTH-1:0]   rdata_r;

  logic [IDX-1:0]          req_idx_s, hint_idx_s, mem_idx_s, line_idx_s;
  logic [TAG_W-1:0]        req_tag_s, hint_tag_s, mem_tag_s, line_tag_s;
  logic [DATA_WIDTH-1:0]   req_line_s, merged_s, line_data_s;
  logic                    req_hit_s, hint_hit_s, line_we_s, idle_s, gnt_s;
  logic [ADDR_WIDTH-1:0]   hint_addr_s;
  logic                    hint_push_s, hint_pop_s, hint_full_s, hint_empty_s;
  logic                    unused_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign gnt_s       = proc_cache_data_req_i & idle_s & ~rst;
  assign hint_push_s = trace_capture_enable & trace_in[TRACE_VALID_BIT];
  assign hint_pop_s  = idle_s & ~proc_cache_data_req_i & ~hint_empty_s;
  assign unused_s    = ^{trace_in, proc_cache_data_addr_i[1:0], hint_addr_s[1:0], hint_full_s};

  enokida_hint_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .HINT_DEPTH (HINT_DEPTH)
  ) u_hint_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (hint_push_s),
    .push_addr (trace_in[TRACE_ADDR_LSB +: ADDR_WIDTH]),
    .pop       (hint_pop_s),
    .pop_addr  (hint_addr_s),
    .full      (hint_full_s),
    .empty     (hint_empty_s)
  );

  // tag lookups, byte merge and the single line write port
  always_comb begin
    req_idx_s  = proc_cache_data_addr_i[IDX+1:2];
    req_tag_s  = proc_cache_data_addr_i[ADDR_WIDTH-1:IDX+2];
    hint_idx_s = hint_addr_s[IDX+1:2];
    hint_tag_s = hint_addr_s[ADDR_WIDTH-1:IDX+2];
    mem_idx_s  = mem_addr_r[IDX+1:2];
    mem_tag_s  = mem_addr_r[ADDR_WIDTH-1:IDX+2];
    req_line_s = data_r[req_idx_s];
    req_hit_s  = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    hint_hit_s = valid_r[hint_idx_s] && (tag_r[hint_idx_s] == hint_tag_s);
    merged_s   = req_line_s;
    for (int b = 0; b < BE_W; b++) begin
      if (proc_cache_data_be_i[b]) begin
        merged_s[8*b +: 8] = proc_cache_data_wdata_i[8*b +: 8];
      end else begin
        merged_s[8*b +: 8] = req_line_s[8*b +: 8];
      end
    end
    line_we_s   = 1'b0;
    line_idx_s  = req_idx_s;
    line_tag_s  = req_tag_s;
    line_data_s = merged_s;
    if (gnt_s && proc_cache_data_we_i && req_hit_s) begin
      line_we_s = 1'b1;
    end else if ((((state_r == ST_MEM_WAIT) && !mem_we_r) || (state_r == ST_PF_WAIT))
                 && cache_mem_data_rvalid_i && !lock) begin
      line_we_s   = 1'b1;
      line_idx_s  = mem_idx_s;
      line_tag_s  = mem_tag_s;
      line_data_s = cache_mem_data_rdata_i;
    end else begin
      line_we_s = 1'b0;
    end
  end

  // line valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {NUM_LINES{1'b0}};
    end else if (line_we_s) begin
      valid_r[line_idx_s] <= 1'b1;
    end
  end

  // line tag and data storage
  always_ff @(posedge clk) begin
    if (line_we_s) begin
      tag_r[line_idx_s]  <= line_tag_s;
      data_r[line_idx_s] <= line_data_s;
    end
  end

  // control FSM with registered processor and memory outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_we_r    <= 1'b0;
      mem_be_r    <= {BE_W{1'b0}};
      mem_wdata_r <= {DATA_WIDTH{1'b0}};
      rvalid_r    <= 1'b0;
      rdata_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (proc_cache_data_req_i) begin
            if (!proc_cache_data_we_i && req_hit_s) begin
              rvalid_r <= 1'b1;
              rdata_r  <= req_line_s;
              state_r  <= ST_RESP;
            end else begin
              mem_req_r   <= 1'b1;
              mem_addr_r  <= proc_cache_data_addr_i;
              mem_we_r    <= proc_cache_data_we_i;
              mem_be_r    <= proc_cache_data_be_i;
              mem_wdata_r <= proc_cache_data_wdata_i;
              state_r     <= ST_MEM_REQ;
            end
          end else if (!hint_empty_s && !hint_hit_s && !lock) begin
            mem_req_r   <= 1'b1;
            mem_addr_r  <= hint_addr_s;
            mem_we_r    <= 1'b0;
            mem_be_r    <= {BE_W{1'b1}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            state_r     <= ST_PF_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MEM_REQ: begin
          if (cache_mem_data_gnt_i) begin
            mem_req_r <= 1'b0;
            state_r   <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (cache_mem_data_rvalid_i) begin
            rvalid_r <= 1'b1;
            rdata_r  <= mem_we_r ? {DATA_WIDTH{1'b0}} : cache_mem_data_rdata_i;
            state_r  <= ST_RESP;
          end
        end
        ST_RESP: begin
          rvalid_r <= 1'b0;
          rdata_r  <= {DATA_WIDTH{1'b0}};
          state_r  <= ST_IDLE;
        end
        ST_PF_REQ: begin
          if (cache_mem_data_gnt_i) begin
            mem_req_r <= 1'b0;
            state_r   <= ST_PF_WAIT;
          end
        end
        ST_PF_WAIT: begin
          if (cache_mem_data_rvalid_i) state_r <= ST_IDLE;
        end
        default: begin
          mem_req_r <= 1'b0;
          rvalid_r  <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign proc_cache_data_gnt_o    = gnt_s;
  assign proc_cache_data_rvalid_o = rvalid_r;
  assign proc_cache_data_rdata_o  = rdata_r;
  assign cache_mem_data_req_o     = mem_req_r;
  assign cache_mem_data_addr_o    = mem_addr_r;
  assign cache_mem_data_we_o      = mem_we_r;
  assign cache_mem_data_be_o      = mem_be_r;
  assign cache_mem_data_wdata_o   = mem_wdata_r;

`ifdef ENOKIDA_CACHE_STATS_EN
  logic [31:0] hits_r, misses_r, pf_fills_r, drops_r;

  // saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_r     <= 32'd0;
      misses_r   <= 32'd0;
      pf_fills_r <= 32'd0;
      drops_r    <= 32'd0;
    end else begin
      if (gnt_s && !proc_cache_data_we_i && req_hit_s)  hits_r   <= sat_inc(hits_r);
      if (gnt_s && !proc_cache_data_we_i && !req_hit_s) misses_r <= sat_inc(misses_r);
      if ((state_r == ST_PF_WAIT) && cache_mem_data_rvalid_i && !lock) pf_fills_r <= sat_inc(pf_fills_r);
      if (hint_push_s && hint_full_s && !hint_pop_s) drops_r <= sat_inc(drops_r);
    end
  end

  assign stat_hits_o       = hits_r;
  assign stat_misses_o     = misses_r;
  assign stat_pf_fills_o   = pf_fills_r;
  assign stat_hint_drops_o = drops_r;
`endif

endmodule
